ack_bus_sched: RTL and testbench
================================

// Module: ack_bus_sched
// PURPOSE
//   Clocked, parametrised successor to the combinational ACK-bus arbiter. It serves
//   N_SRC requesters and issues one registered one-hot grant that is held for the
//   whole transaction. Arbitration is fixed-priority (wired-AND, lowest ID wins) or
//   round-robin. The block sits between the crypto engines / MEM / CTRL and the
//   shared ACK return path.
// PARAMETERS
//   N_SRC    4   number of requesters, legal range 2..16; source i has ID i
//   MODE     0   0 = fixed priority, lowest ID wins; 1 = round-robin, search starts at last winner+1
//   TIMEOUT  64  maximum GRANT cycles before forced release (used only with ACK_BUS_TIMEOUT_EN); >=2
//   ID_W     localparam = $clog2(N_SRC)
// PORTS
//   clk            in   1      single clock, rising edge
//   rst            in   1      synchronous reset, active-high
//   req_i          in   N_SRC  level request per source; held high until the source is finished
//   grant_o        out  N_SRC  registered one-hot READY grant; all zeros when idle
//   winner_id_o    out  ID_W   ID of the current/last winner, registered
//   ack_event_o    out  1      one-cycle pulse in the first cycle of every new grant
//   busy_o         out  1      high while in GRANT
//   ack_valid_n_o  out  1      combinational debug: ~|req_i (resolved open-drain valid_n)
//   ack_id_o       out  ID_W   combinational debug: bitwise AND of the IDs of all active requesters; all ones when none
//   timeout_o      out  1      one-cycle pulse on a forced release
// BEHAVIOUR
//   Reset values: grant_o=0, winner_id_o=0, ack_event_o=0, busy_o=0, timeout_o=0.
//     Also state=IDLE, rr pointer=N_SRC-1 (so source 0 has first RR priority), masks=0, counter=0.
//   Eligibility: req_eff = req_i & ~mask. The mask is always 0 without the timeout feature.
//   FSM states: IDLE, GRANT.
//   IDLE:
//     - If |req_eff is sampled at edge e, at edge e the block selects the winner,
//       sets grant_o and winner_id_o, pulses ack_event_o, and moves to GRANT.
//     - Latency: req high in the cycle before edge e -> grant visible after edge e (1 cycle).
//     - MODE 0: winner = lowest set index of req_eff.
//     - MODE 1: winner = first set index scanning ptr+1, ptr+2, ... modulo N_SRC.
//       ptr <= winner on every grant.
//   GRANT:
//     - grant_o and winner_id_o are stable. Changes on other req bits are ignored (no preemption).
//     - If req_i[winner] is sampled low: grant_o <= 0, go to IDLE. That source may be re-granted at the next edge.
//     - This gives a minimum of 1 idle cycle (grant_o=0) between two grants.
//   Simultaneous events:
//     - Multiple requests in the same cycle are resolved by MODE.
//     - A source that drops and re-raises req while in IDLE competes normally.
//   A req pulse shorter than one cycle that is not sampled on an edge is lost. This is by design.
//   Reset mid-GRANT: at the reset edge grant_o drops to 0. No ack_event_o or timeout_o pulse is emitted.
// CONFIGURATION
//   Macro ACK_BUS_TIMEOUT_EN.
//   Defined:
//     - A cycle counter runs in GRANT, starting at 0 on the grant edge.
//     - If the counter reaches TIMEOUT-1 while req_i[winner] is still high:
//       grant_o <= 0, timeout_o pulses, mask[winner] <= 1, state -> IDLE.
//     - mask[i] clears on the first edge where req_i[i] is sampled low.
//     - Normal release takes precedence over timeout in the same cycle (no pulse, no mask).
//   Undefined:
//     - No counter and no mask; timeout_o is tied to 0.
//     - A grant is held indefinitely while its req stays high.
// TESTING
//   1. Reset then idle: req_i=0 for 10 cycles -> grant_o=0, busy_o=0, ack_valid_n_o=1, ack_id_o=2'b11.
//   2. MODE=0, req_i=4'b1110 for one edge -> grant_o=4'b0010, winner_id_o=1, ack_event_o one pulse,
//      ack_id_o=2'b00 (01&10&11). Drop req[1] -> after 1 idle cycle grant_o=4'b0100.
//   3. MODE=1, req_i=4'b1111 held; each winner drops for 1 cycle after its grant
//      -> grants 0,1,2,3,0 in order, 4 ack_event_o pulses per lap.
//   4. Timeout (macro on, TIMEOUT=8): req_i=4'b0001 held -> grant for 8 cycles, then timeout_o pulse, grant_o=0.
//      Source 0 stays ungranted while held. Drop for 1 cycle and re-raise -> granted again.
//   5. Reset mid-GRANT (req_i=4'b0100, 3 cycles into grant, rst=1 for 1 edge)
//      -> grant_o=0 and winner_id_o=0 next cycle, no pulses. After rst=0, re-grant after 1 edge.
//   6. Release plus new request in the same cycle: req 4'b0001 -> 4'b0010 swap
//      -> grant_o 0001, then 0000, then 0010.

Source files
------------

// File: rtl/ack_bus_sched.sv
// ack_bus_sched: clocked N_SRC-way ACK-bus arbiter (fixed priority or round-robin) that holds a one-hot grant per transaction.
// Optional forced release after TIMEOUT grant cycles: define ACK_BUS_TIMEOUT_EN.
module ack_bus_sched #(
  parameter int N_SRC   = 4,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 64,
  localparam int ID_W   = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req_i,
  output logic [N_SRC-1:0] grant_o,
  output logic [ID_W-1:0]  winner_id_o,
  output logic             ack_event_o,
  output logic             busy_o,
  output logic             ack_valid_n_o,
  output logic [ID_W-1:0]  ack_id_o,
  output logic             timeout_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [N_SRC-1:0] ONE_N  = {{(N_SRC-1){1'b0}}, 1'b1};
  localparam logic [N_SRC-1:0] ZERO_N = {N_SRC{1'b0}};
  localparam logic [ID_W-1:0]  ZERO_ID = {ID_W{1'b0}};
  localparam logic [ID_W-1:0]  ONES_ID = {ID_W{1'b1}};

  function automatic logic [N_SRC-1:0] f_onehot(input logic [ID_W-1:0] id);
    return ONE_N << id;
  endfunction

  // First set bit of v, scanning upward from index start (wrapping modulo N_SRC).
  function automatic logic [ID_W-1:0] f_first_from(input logic [N_SRC-1:0] v, input int start);
    logic [ID_W-1:0] sel;
    int              idx;
    sel = ZERO_ID;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = (start + k) % N_SRC;
      sel = (|(v & (ONE_N << idx))) ? ID_W'(idx) : sel;
    end
    return sel;
  endfunction

  state_t           r_state;
  logic [N_SRC-1:0] r_grant;
  logic [ID_W-1:0]  r_winner;
  logic [ID_W-1:0]  r_ptr;
  logic             r_ack_event;
  logic             r_busy;
  logic             r_timeout;

  logic [N_SRC-1:0] w_req_eff;
  logic [ID_W-1:0]  w_win;
  logic             w_win_req;
  logic [ID_W-1:0]  w_ack_id;

`ifdef ACK_BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [N_SRC-1:0] r_mask;
  logic [CNT_W-1:0] r_cnt;
  assign w_req_eff = req_i & ~r_mask;
`else
  assign w_req_eff = req_i;
`endif

  assign w_win_req = |(req_i & f_onehot(r_winner));

  // Winner selection for the next grant according to MODE.
  always_comb begin
    w_win = ZERO_ID;
    if (MODE == 1) begin
      w_win = f_first_from(w_req_eff, int'(r_ptr) + 1);
    end else begin
      w_win = f_first_from(w_req_eff, 0);
    end
  end

  // Debug view of the wired-AND ID bus: all ones when nobody drives it.
  always_comb begin
    w_ack_id = ONES_ID;
    for (int i = 0; i < N_SRC; i++) begin
      w_ack_id = w_ack_id & (req_i[i] ? ID_W'(i) : ONES_ID);
    end
  end

  // Arbiter FSM with registered grant, winner and event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= ZERO_N;
      r_winner    <= ZERO_ID;
      r_ptr       <= ID_W'(N_SRC - 1);
      r_ack_event <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
`ifdef ACK_BUS_TIMEOUT_EN
      r_mask      <= ZERO_N;
      r_cnt       <= {CNT_W{1'b0}};
`endif
    end else begin
      r_ack_event <= 1'b0;
      r_timeout   <= 1'b0;
`ifdef ACK_BUS_TIMEOUT_EN
      // A masked source becomes eligible again once it has been seen idle.
      r_mask      <= r_mask & req_i;
`endif
      case (r_state)
        ST_IDLE: begin
          if (|w_req_eff) begin
            r_grant     <= f_onehot(w_win);
            r_winner    <= w_win;
            r_ptr       <= w_win;
            r_ack_event <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_GRANT;
`ifdef ACK_BUS_TIMEOUT_EN
            r_cnt       <= {CNT_W{1'b0}};
`endif
          end else begin
            r_grant <= ZERO_N;
            r_busy  <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (!w_win_req) begin
            r_grant <= ZERO_N;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
`ifdef ACK_BUS_TIMEOUT_EN
          end else if (r_cnt == CNT_LAST) begin
            r_grant   <= ZERO_N;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
            r_timeout <= 1'b1;
            r_mask    <= (r_mask & req_i) | r_grant;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
`else
          end else begin
            r_grant <= r_grant;
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= ZERO_N;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_o       = r_grant;
  assign winner_id_o   = r_winner;
  assign ack_event_o   = r_ack_event;
  assign busy_o        = r_busy;
  assign timeout_o     = r_timeout;
  assign ack_valid_n_o = ~|req_i;
  assign ack_id_o      = w_ack_id;

endmodule

// File: tb/tb_ack_bus_sched.sv
// Bench for ack_bus_sched: fixed-priority and round-robin instances, table vectors plus corner-case sequences.
module tb_ack_bus_sched;

  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] req_fp, req_rr;
  logic [3:0] fp_grant, rr_grant;
  logic [1:0] fp_win, rr_win, fp_id, rr_id;
  logic       fp_ev, rr_ev, fp_busy, rr_busy, fp_vn, rr_vn, fp_to, rr_to;

  ack_bus_sched #(.N_SRC(4), .MODE(0), .TIMEOUT(TO)) u_fp (
    .clk(clk), .rst(rst), .req_i(req_fp), .grant_o(fp_grant), .winner_id_o(fp_win),
    .ack_event_o(fp_ev), .busy_o(fp_busy), .ack_valid_n_o(fp_vn), .ack_id_o(fp_id), .timeout_o(fp_to));

  ack_bus_sched #(.N_SRC(4), .MODE(1), .TIMEOUT(TO)) u_rr (
    .clk(clk), .rst(rst), .req_i(req_rr), .grant_o(rr_grant), .winner_id_o(rr_win),
    .ack_event_o(rr_ev), .busy_o(rr_busy), .ack_valid_n_o(rr_vn), .ack_id_o(rr_id), .timeout_o(rr_to));

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] win;
    logic       ev;
    logic       busy;
    logic       vn;
    logic [1:0] id;
  } vec_t;

  vec_t tbl[11];
  vec_t exp_q[$];
  int   rr_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_v(input int i, input logic [3:0] req, input logic [3:0] grant, input logic [1:0] win,
                       input logic ev, input logic busy, input logic vn, input logic [1:0] id);
    tbl[i].req = req; tbl[i].grant = grant; tbl[i].win = win;
    tbl[i].ev = ev; tbl[i].busy = busy; tbl[i].vn = vn; tbl[i].id = id;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t e;
    int   last, w, n_ev, cnt;
    bit   found, seen_to;

    //        req      grant    win    ev    busy  vn    id
    set_v(0,  4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 2'b11);
    set_v(1,  4'b1110, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 2'b00);
    set_v(2,  4'b1110, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0, 2'b00);
    set_v(3,  4'b1100, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 2'b10);
    set_v(4,  4'b1100, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 2'b10);
    set_v(5,  4'b1000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 2'b11);
    set_v(6,  4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 2'b11);
    set_v(7,  4'b1001, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b0, 2'b00);
    set_v(8,  4'b0001, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0, 2'b00);
    set_v(9,  4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 2'b00);
    set_v(10, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 2'b11);

    rst = 1'b1; req_fp = 4'b0000; req_rr = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset grant", fp_grant, 4'b0000);
    chk("reset winner", fp_win, 2'd0);
    chk("reset event", fp_ev, 1'b0);
    chk("reset busy", fp_busy, 1'b0);
    chk("reset timeout", fp_to, 1'b0);
    chk("reset rr grant", rr_grant, 4'b0000);
    rst = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle grant", fp_grant, 4'b0000);
      chk("idle busy", fp_busy, 1'b0);
      chk("idle valid_n", fp_vn, 1'b1);
      chk("idle ack_id", fp_id, 2'b11);
    end

    for (int i = 0; i < 11; i++) begin
      req_fp = tbl[i].req;
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("vec%0d grant", i), fp_grant, e.grant);
      chk($sformatf("vec%0d winner", i), fp_win, e.win);
      chk($sformatf("vec%0d event", i), fp_ev, e.ev);
      chk($sformatf("vec%0d busy", i), fp_busy, e.busy);
      chk($sformatf("vec%0d valid_n", i), fp_vn, e.vn);
      chk($sformatf("vec%0d ack_id", i), fp_id, e.id);
    end

    // release of one source and request of another in the same cycle
    req_fp = 4'b0001;
    @(negedge clk); chk("swap grant0", fp_grant, 4'b0001);
    req_fp = 4'b0010;
    @(negedge clk); chk("swap gap", fp_grant, 4'b0000);
    @(negedge clk); chk("swap grant1", fp_grant, 4'b0010);
    chk("swap winner", fp_win, 2'd1);
    req_fp = 4'b0000;
    @(negedge clk);

    // reset in the middle of a grant
    req_fp = 4'b0100;
    @(negedge clk); chk("rstmid grant", fp_grant, 4'b0100);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid grant cleared", fp_grant, 4'b0000);
    chk("rstmid winner cleared", fp_win, 2'd0);
    chk("rstmid no event", fp_ev, 1'b0);
    chk("rstmid no timeout", fp_to, 1'b0);
    chk("rstmid busy", fp_busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid regrant", fp_grant, 4'b0100);
    chk("rstmid regrant event", fp_ev, 1'b1);
    req_fp = 4'b0000;
    @(negedge clk);

    // round-robin: all four request, each winner drops for one cycle
    last = 3;
    for (int g = 0; g < 5; g++) begin
      last = (last + 1) % 4;
      rr_q.push_back(last);
    end
    n_ev = 0;
    req_rr = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      found = 1'b0;
      for (int c = 0; c < 4 && !found; c++) begin
        @(negedge clk);
        if (rr_ev) found = 1'b1;
      end
      chk($sformatf("rr%0d event seen", g), found, 1'b1);
      w = rr_q.pop_front();
      if (found) n_ev++;
      chk($sformatf("rr%0d grant", g), rr_grant, 4'b0001 << w);
      chk($sformatf("rr%0d winner", g), rr_win, w);
      req_rr = 4'b1111 & ~(4'b0001 << w);
      @(negedge clk);
      chk($sformatf("rr%0d gap", g), rr_grant, 4'b0000);
      req_rr = 4'b1111;
    end
    chk("rr event count", n_ev, 5);
    chk("rr valid_n", rr_vn, 1'b0);
    req_rr = 4'b0000;
    @(negedge clk);

`ifdef ACK_BUS_TIMEOUT_EN
    req_fp = 4'b0001;
    cnt = 0; seen_to = 1'b0;
    for (int c = 0; c < 20 && !seen_to; c++) begin
      @(negedge clk);
      if (fp_grant == 4'b0001) cnt++;
      if (fp_to) seen_to = 1'b1;
    end
    chk("timeout pulse", seen_to, 1'b1);
    chk("timeout grant cycles", cnt, TO);
    chk("timeout grant dropped", fp_grant, 4'b0000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("timeout masked", fp_grant, 4'b0000);
      chk("timeout single pulse", fp_to, 1'b0);
    end
    req_fp = 4'b0000;
    @(negedge clk);
    req_fp = 4'b0001;
    @(negedge clk);
    chk("timeout regrant", fp_grant, 4'b0001);
    chk("timeout regrant event", fp_ev, 1'b1);
`else
    req_fp = 4'b0001;
    seen_to = 1'b0;
    @(negedge clk);
    chk("hold event", fp_ev, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fp_to) seen_to = 1'b1;
    end
    chk("hold grant", fp_grant, 4'b0001);
    chk("hold no timeout", seen_to, 1'b0);
`endif
    req_fp = 4'b0000;
    @(negedge clk);
    chk("final idle", fp_grant, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
